// File: rtl/rv_pkg.sv
// Shared RV32I core definitions: datapath width, branch condition codes and
// PC-unit state encoding.
package rv_pkg;

    localparam int unsigned XLEN = 32;

    // B-type funct3 condition codes; 3'b010 and 3'b011 are unused encodings.
    typedef enum logic [2:0] {
        BEQ  = 3'b000,
        BNE  = 3'b001,
        BLT  = 3'b100,
        BGE  = 3'b101,
        BLTU = 3'b110,
        BGEU = 3'b111
    } br_funct3_e;

    typedef enum logic {
        PC_RUN  = 1'b0,
        PC_TRAP = 1'b1
    } pc_state_e;

endpackage

// File: rtl/branch_pc_unit_if.sv
// Decode/ALU <-> PC unit bundle.
//   master : decode/ALU side, drives instruction info and flags, sees PC outputs
//   slave  : branch_pc_unit
// BRANCH_STATS_EN adds the br_total_cnt / br_taken_cnt counters.
interface branch_pc_unit_if;
    import rv_pkg::*;

    logic            instr_valid;
    logic            stall;
    logic            is_branch;
    logic            is_jal;
    logic            is_jalr;
    logic [2:0]      funct3;
    logic            zero;
    logic            less_signed;
    logic            less_unsigned;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic            branch_taken;
    logic            instr_kill;
    logic            misalign_trap;
    logic [XLEN-1:0] trap_pc;
`ifdef BRANCH_STATS_EN
    logic [31:0]     br_total_cnt;
    logic [31:0]     br_taken_cnt;

    modport master (
        output instr_valid, stall, is_branch, is_jal, is_jalr, funct3,
               zero, less_signed, less_unsigned, imm, rs1_val,
        input  pc, pc_plus4, branch_taken, instr_kill, misalign_trap, trap_pc,
               br_total_cnt, br_taken_cnt
    );
    modport slave (
        input  instr_valid, stall, is_branch, is_jal, is_jalr, funct3,
               zero, less_signed, less_unsigned, imm, rs1_val,
        output pc, pc_plus4, branch_taken, instr_kill, misalign_trap, trap_pc,
               br_total_cnt, br_taken_cnt
    );
`else
    modport master (
        output instr_valid, stall, is_branch, is_jal, is_jalr, funct3,
               zero, less_signed, less_unsigned, imm, rs1_val,
        input  pc, pc_plus4, branch_taken, instr_kill, misalign_trap, trap_pc
    );
    modport slave (
        input  instr_valid, stall, is_branch, is_jal, is_jalr, funct3,
               zero, less_signed, less_unsigned, imm, rs1_val,
        output pc, pc_plus4, branch_taken, instr_kill, misalign_trap, trap_pc
    );
`endif

endinterface

// File: rtl/branch_pc_unit_cond.sv
// Branch condition resolve: funct3 + ALU compare flags -> cond.
//   funct3, zero, less_signed, less_unsigned in; cond out (combinational).
module branch_cond
    import rv_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       less_signed,
    input  logic       less_unsigned,
    output logic       cond
);

    always_comb begin
        cond = 1'b0;
        case (funct3)
            BEQ:     cond = zero;
            BNE:     cond = !zero;
            BLT:     cond = less_signed;
            BGE:     cond = !less_signed;
            BLTU:    cond = less_unsigned;
            BGEU:    cond = !less_unsigned;
            default: cond = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_pc_unit.sv
// PC register and control-flow resolve for the single-cycle RV32I core.
//   clk, rst_n : core clock, async active-low reset
//   bus        : branch_pc_unit_if.slave (instruction info in, PC/trap out)
// Optional: BRANCH_STATS_EN adds saturating branch total/taken counters.
module branch_pc_unit
    import rv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100
)(
    input  logic             clk,
    input  logic             rst_n,
    branch_pc_unit_if.slave  bus
);

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    pc_state_e       state_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] trap_pc_q;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] jalr_sum;
    logic [XLEN-1:0] target;
    logic            cond;
    logic            in_run;
    logic            taken;
    logic            misaligned;

    branch_cond u_cond (
        .funct3        (bus.funct3),
        .zero          (bus.zero),
        .less_signed   (bus.less_signed),
        .less_unsigned (bus.less_unsigned),
        .cond          (cond)
    );

    // Redirect resolve; jalr wins over jal/branch when several are set.
    // Nothing redirects while the trap state owns the PC.
    always_comb begin
        in_run     = (state_q == PC_RUN);
        pc_plus4   = pc_q + PC_STEP;
        jalr_sum   = bus.rs1_val + bus.imm;
        taken      = in_run && bus.instr_valid &&
                     (bus.is_jalr || bus.is_jal || (bus.is_branch && cond));
        target     = pc_plus4;
        if (taken) begin
            if (bus.is_jalr) target = {jalr_sum[XLEN-1:1], 1'b0};
            else             target = pc_q + bus.imm;
        end
        misaligned = taken && target[1];
    end

    // PC / trap state machine
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= PC_RUN;
            pc_q      <= RESET_VECTOR;
            trap_pc_q <= '0;
        end else begin
            case (state_q)
                PC_RUN: begin
                    if (!bus.stall && bus.instr_valid) begin
                        if (misaligned) begin
                            trap_pc_q <= pc_q;
                            state_q   <= PC_TRAP;
                        end else begin
                            pc_q <= target;
                        end
                    end
                end
                PC_TRAP: begin
                    pc_q    <= TRAP_VECTOR;
                    state_q <= PC_RUN;
                end
                default: state_q <= PC_RUN;
            endcase
        end
    end

    assign bus.pc            = pc_q;
    assign bus.pc_plus4      = pc_plus4;
    assign bus.branch_taken  = taken && !misaligned;
    assign bus.instr_kill    = !in_run || misaligned;
    assign bus.misalign_trap = !in_run;
    assign bus.trap_pc       = trap_pc_q;

`ifdef BRANCH_STATS_EN
    logic [31:0] br_total_q;
    logic [31:0] br_taken_q;
    logic        br_commit;

    // A branch commits when it wins priority, retires and does not trap.
    assign br_commit = in_run && bus.instr_valid && !bus.stall && !misaligned &&
                       bus.is_branch && !bus.is_jal && !bus.is_jalr;

    // Saturating branch counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_total_q <= '0;
            br_taken_q <= '0;
        end else if (br_commit) begin
            if (br_total_q != '1)         br_total_q <= br_total_q + 32'd1;
            if (cond && br_taken_q != '1) br_taken_q <= br_taken_q + 32'd1;
        end
    end

    assign bus.br_total_cnt = br_total_q;
    assign bus.br_taken_cnt = br_taken_q;
`endif

endmodule

// File: tb/tb_branch_pc_unit.sv
module tb_branch_pc_unit;
    import rv_pkg::*;

    localparam logic [31:0] RST_VEC  = 32'h0000_0000;
    localparam logic [31:0] TRAP_VEC = 32'h0000_0100;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    branch_pc_unit_if bus();

    branch_pc_unit #(.RESET_VECTOR(RST_VEC), .TRAP_VECTOR(TRAP_VEC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_pc = RST_VEC;
    logic        m_trap = 1'b0;
    logic [31:0] m_trap_pc = 32'h0;

    // What the current inputs mean for the architectural state.
    function automatic void model_eval(output logic redirect, output logic kill,
                                       output logic fault, output logic [31:0] nxt);
        logic c;
        logic jump;
        logic [31:0] dest;
        case (bus.funct3)
            3'd0: c = bus.zero;
            3'd1: c = !bus.zero;
            3'd4: c = bus.less_signed;
            3'd5: c = !bus.less_signed;
            3'd6: c = bus.less_unsigned;
            3'd7: c = !bus.less_unsigned;
            default: c = 1'b0;
        endcase
        jump = !m_trap && bus.instr_valid &&
               (bus.is_jalr || bus.is_jal || (bus.is_branch && c));
        if (!jump)           dest = m_pc + 32'd4;
        else if (bus.is_jalr) dest = (bus.rs1_val + bus.imm) & 32'hFFFF_FFFE;
        else                 dest = m_pc + bus.imm;
        fault    = jump && dest[1];
        redirect = jump && !fault;
        kill     = m_trap || fault;
        nxt      = dest;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        logic r, k, f;
        logic [31:0] n;
        if (!rst_n) begin
            m_pc      <= RST_VEC;
            m_trap    <= 1'b0;
            m_trap_pc <= 32'h0;
        end else begin
            model_eval(r, k, f, n);
            if (m_trap) begin
                m_pc   <= TRAP_VEC;
                m_trap <= 1'b0;
            end else if (!bus.stall && bus.instr_valid) begin
                if (f) begin
                    m_trap    <= 1'b1;
                    m_trap_pc <= m_pc;
                end else begin
                    m_pc <= n;
                end
            end
        end
    end

    // Compare every cycle, mid-cycle.
    always @(negedge clk) begin
        logic r, k, f;
        logic [31:0] n;
        model_eval(r, k, f, n);
        chk("pc", bus.pc, m_pc);
        chk("pc_plus4", bus.pc_plus4, m_pc + 32'd4);
        chk("branch_taken", 32'(bus.branch_taken), 32'(r));
        chk("instr_kill", 32'(bus.instr_kill), 32'(k));
        chk("misalign_trap", 32'(bus.misalign_trap), 32'(m_trap));
        if (m_trap) chk("trap_pc", bus.trap_pc, m_trap_pc);
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic st, input logic br,
                          input logic jal, input logic jalr, input logic [2:0] f3,
                          input logic z, input logic ls, input logic lu,
                          input logic [31:0] imm, input logic [31:0] rs1);
        bus.instr_valid   = v;
        bus.stall         = st;
        bus.is_branch     = br;
        bus.is_jal        = jal;
        bus.is_jalr       = jalr;
        bus.funct3        = f3;
        bus.zero          = z;
        bus.less_signed   = ls;
        bus.less_unsigned = lu;
        bus.imm           = imm;
        bus.rs1_val       = rs1;
    endtask

    task automatic plain();
        set_in(1, 0, 0, 0, 0, 3'd0, 0, 0, 0, 32'h0, 32'h0);
    endtask

    task automatic goto_pc(input logic [31:0] dest);
        set_in(1, 0, 0, 0, 1, 3'd0, 0, 0, 0, 32'h0, dest);
        step();
        chk("goto_pc", bus.pc, dest);
    endtask

    // Misaligned JAL from 0x80, optionally stalling during the trap cycle.
    task automatic trap_seq(input logic stall_in_trap);
        goto_pc(32'h80);
        set_in(1, 0, 0, 1, 0, 3'd0, 0, 0, 0, 32'h6, 32'h0);
        @(negedge clk);
        chk("jal_mis_kill", 32'(bus.instr_kill), 32'd1);
        chk("jal_mis_taken", 32'(bus.branch_taken), 32'd0);
        chk("jal_mis_notrap_yet", 32'(bus.misalign_trap), 32'd0);
        step();
        bus.stall = stall_in_trap;
        #1;
        chk("trap_active", 32'(bus.misalign_trap), 32'd1);
        chk("trap_pc", bus.trap_pc, 32'h80);
        chk("trap_pc_hold", bus.pc, 32'h80);
        chk("trap_kill", 32'(bus.instr_kill), 32'd1);
        step();
        chk("trap_vector", bus.pc, 32'h100);
        chk("trap_done", 32'(bus.misalign_trap), 32'd0);
        plain();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        plain();
        rst_n = 1'b0;
        // reset held for 3 cycles
        repeat (3) begin
            @(negedge clk);
            chk("reset_pc", bus.pc, 32'h0);
            chk("reset_trap", 32'(bus.misalign_trap), 32'd0);
            chk("reset_kill", 32'(bus.instr_kill), 32'd0);
        end
        rst_n = 1'b1;
        step();
        chk("first_pc", bus.pc, 32'h4);

        // BEQ taken / not-taken from 0x40
        set_in(1, 0, 0, 1, 0, 3'd0, 0, 0, 0, 32'h3C, 32'h0);
        step();
        chk("pc_0x40", bus.pc, 32'h40);
        set_in(1, 0, 1, 0, 0, 3'd0, 1, 0, 0, 32'hFFFF_FFF0, 32'h0);
        @(negedge clk);
        chk("beq_taken", 32'(bus.branch_taken), 32'd1);
        step();
        chk("beq_target", bus.pc, 32'h30);
        set_in(1, 0, 0, 1, 0, 3'd0, 0, 0, 0, 32'h10, 32'h0);
        step();
        set_in(1, 0, 1, 0, 0, 3'd0, 0, 0, 0, 32'hFFFF_FFF0, 32'h0);
        @(negedge clk);
        chk("beq_not_taken", 32'(bus.branch_taken), 32'd0);
        step();
        chk("beq_fall", bus.pc, 32'h44);

        // BLTU taken, BGE not taken
        set_in(1, 0, 1, 0, 0, 3'd6, 0, 0, 1, 32'h20, 32'h0);
        step();
        chk("bltu_target", bus.pc, 32'h64);
        set_in(1, 0, 1, 0, 0, 3'd5, 0, 1, 0, 32'h20, 32'h0);
        step();
        chk("bge_fall", bus.pc, 32'h68);

        // JALR with bit0 cleared, stalled two cycles
        set_in(1, 1, 0, 0, 1, 3'd0, 0, 0, 0, 32'h0, 32'h1001);
        @(negedge clk);
        chk("jalr_link", bus.pc_plus4, 32'h6C);
        chk("jalr_taken", 32'(bus.branch_taken), 32'd1);
        step();
        chk("stall_hold1", bus.pc, 32'h68);
        step();
        chk("stall_hold2", bus.pc, 32'h68);
        bus.stall = 1'b0;
        step();
        chk("jalr_target", bus.pc, 32'h1000);

        trap_seq(1'b0);
        trap_seq(1'b1);

        // Reset during the trap cycle aborts the redirect
        goto_pc(32'h80);
        set_in(1, 0, 0, 1, 0, 3'd0, 0, 0, 0, 32'h6, 32'h0);
        step();
        chk("pre_abort_trap", 32'(bus.misalign_trap), 32'd1);
        rst_n = 1'b0;
        plain();
        #1;
        chk("abort_pc", bus.pc, 32'h0);
        chk("abort_trap", 32'(bus.misalign_trap), 32'd0);
        step();
        chk("abort_no_redirect", bus.pc, 32'h0);
        rst_n = 1'b1;
        step();
        chk("abort_restart", bus.pc, 32'h4);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            int t;
            logic [31:0] imm;
            step();
            case ($urandom_range(0, 3))
                0: imm = $urandom;
                1: begin t = $urandom_range(0, 511); imm = 32'((t - 256) * 4); end
                2: begin t = $urandom_range(0, 63); imm = 32'(t - 32); end
                default: imm = 32'h0;
            endcase
            set_in($urandom_range(0, 99) < 85, $urandom_range(0, 99) < 20,
                   1'($urandom), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
                   3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                   imm, $urandom);
        end
        step();
        plain();

`ifdef BRANCH_STATS_EN
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("cnt_total_reset", bus.br_total_cnt, 32'd0);
        chk("cnt_taken_reset", bus.br_taken_cnt, 32'd0);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                set_in(1, 1, 1, 0, 0, 3'd0, 1, 0, 0, 32'h8, 32'h0);
                step();
            end
            set_in(1, 0, 1, 0, 0, 3'd0, 1'(i < 3), 0, 0, 32'h8, 32'h0);
            step();
        end
        plain();
        chk("cnt_total", bus.br_total_cnt, 32'd5);
        chk("cnt_taken", bus.br_taken_cnt, 32'd3);
        force dut.br_total_q = 32'hFFFF_FFFF;
        force dut.br_taken_q = 32'hFFFF_FFFF;
        #1;
        release dut.br_total_q;
        release dut.br_taken_q;
        set_in(1, 0, 1, 0, 0, 3'd0, 1, 0, 0, 32'h8, 32'h0);
        step();
        plain();
        chk("cnt_total_sat", bus.br_total_cnt, 32'hFFFF_FFFF);
        chk("cnt_taken_sat", bus.br_taken_cnt, 32'hFFFF_FFFF);
`endif

        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
